// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline types: decoded control bundle, the NOP control word and the x0 index.
package rv_pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] REG_X0   = 5'd0;

  // Clears every bit that could cause a side effect or a forwarding match.
  function automatic ctrl_t squash_ctrl(ctrl_t c, logic valid);
    ctrl_t r;
    r = c;
    if (!valid) begin
      r.reg_write = 1'b0;
      r.mem_read  = 1'b0;
      r.mem_write = 1'b0;
      r.branch    = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in decode.
module load_use_detect
  import rv_pipe_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       hazard_o
);

  logic ex_is_load;
  logic src_match;

  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != REG_X0);
  assign src_match  = (id_uses_rs1_i & (ex_rd_i == id_rs1_i)) |
                      (id_uses_rs2_i & (ex_rd_i == id_rs2_i));
  assign hazard_o   = ex_is_load & src_match & id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional ID_EX_PERF_CNT_EN adds stall_cycles/flush_cycles event counters.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic [3:0]      id_alu_op,
  input  logic            ex_flush,
  input  logic            hold,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic [3:0]      ex_alu_op,
  output logic            pc_write,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_cycles,
`endif
  output logic            if_id_write
);

  // Remaining bubbles after the one being loaded now.
  localparam logic [1:0] BcntInit = 2'(LOAD_USE_BUBBLES - 1);

  ctrl_t id_ctrl;
  ctrl_t ctrl_q, ctrl_d;
  logic  valid_q, valid_d;
  logic  [1:0] bcnt_q, bcnt_d;
  logic  hazard;

  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    alu_src:    id_alu_src,
    branch:     id_branch,
    alu_op:     id_alu_op
  };

  load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .hazard_o      (hazard)
  );

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    bcnt_d      = bcnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (rst) begin
      bcnt_d = '0;
    end else if (ex_flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      bcnt_d  = '0;
    end else if (hazard || (bcnt_q != '0)) begin
      // Bubble count is fixed at detection; the hazard is not re-checked mid-stall.
      valid_d     = 1'b0;
      ctrl_d      = CTRL_NOP;
      bcnt_d      = (bcnt_q == '0) ? BcntInit : bcnt_q - 2'd1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      valid_d = id_valid;
      ctrl_d  = squash_ctrl(id_ctrl, id_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      bcnt_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      bcnt_q  <= bcnt_d;
      // Data and indices are don't-care under a bubble, so they load on any non-hold cycle.
      if (!hold) begin
        pc_q       <= id_pc;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rd_q       <= id_rd;
      end
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_op     = ctrl_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
  logic        stall_take, flush_take;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  assign stall_take = ~rst & ~hold & ~ex_flush & (hazard | (bcnt_q != '0));
  assign flush_take = ~rst & ~hold & ex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_take) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_take) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 and 2 load-use bubbles) driven by shared directed
// vectors, checked every cycle against a behavioural model plus hand-computed expectations.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  logic        clk, rst, hold, ex_flush;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  ctrl_t       id_ctrl;

  logic        ex_valid [2];
  logic [31:0] ex_pc [2], ex_rs1_data [2], ex_rs2_data [2], ex_imm [2];
  logic [4:0]  ex_rs1 [2], ex_rs2 [2], ex_rd [2];
  logic        ex_reg_write [2], ex_mem_read [2], ex_mem_write [2];
  logic        ex_mem_to_reg [2], ex_alu_src [2], ex_branch [2];
  logic [3:0]  ex_alu_op [2];
  logic        pc_write [2], if_id_write [2];
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cycles [2], flush_cycles [2];
  logic [31:0] flush_base [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_stage #(.XLEN(32), .LOAD_USE_BUBBLES(g + 1)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_pc         (id_pc),
      .id_rs1_data   (id_rs1_data),
      .id_rs2_data   (id_rs2_data),
      .id_imm        (id_imm),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .id_reg_write  (id_ctrl.reg_write),
      .id_mem_read   (id_ctrl.mem_read),
      .id_mem_write  (id_ctrl.mem_write),
      .id_mem_to_reg (id_ctrl.mem_to_reg),
      .id_alu_src    (id_ctrl.alu_src),
      .id_branch     (id_ctrl.branch),
      .id_alu_op     (id_ctrl.alu_op),
      .ex_flush      (ex_flush),
      .hold          (hold),
      .ex_valid      (ex_valid[g]),
      .ex_pc         (ex_pc[g]),
      .ex_rs1_data   (ex_rs1_data[g]),
      .ex_rs2_data   (ex_rs2_data[g]),
      .ex_imm        (ex_imm[g]),
      .ex_rs1        (ex_rs1[g]),
      .ex_rs2        (ex_rs2[g]),
      .ex_rd         (ex_rd[g]),
      .ex_reg_write  (ex_reg_write[g]),
      .ex_mem_read   (ex_mem_read[g]),
      .ex_mem_write  (ex_mem_write[g]),
      .ex_mem_to_reg (ex_mem_to_reg[g]),
      .ex_alu_src    (ex_alu_src[g]),
      .ex_branch     (ex_branch[g]),
      .ex_alu_op     (ex_alu_op[g]),
      .pc_write      (pc_write[g]),
`ifdef ID_EX_PERF_CNT_EN
      .stall_cycles  (stall_cycles[g]),
      .flush_cycles  (flush_cycles[g]),
`endif
      .if_id_write   (if_id_write[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [u%0d] got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model of the architectural ID/EX state; "pend" counts bubbles still owed after this one.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    ctrl_t       ctrl;
    logic [7:0]  pend;
    logic [31:0] stalls, flushes;
  } model_t;

  model_t m [2];

  function automatic bit m_hazard(model_t s);
    bit load_in_ex = s.valid && s.ctrl.mem_read && (s.rd != 5'd0);
    bit reads = (id_uses_rs1 && (id_rs1 == s.rd)) || (id_uses_rs2 && (id_rs2 == s.rd));
    return load_in_ex && reads && id_valid;
  endfunction

  function automatic bit m_frontend_go(model_t s);
    if (hold) return 1'b0;
    if (rst || ex_flush) return 1'b1;
    return !(s.pend != 0 || m_hazard(s));
  endfunction

  function automatic model_t m_next(model_t s, int bubbles);
    model_t n = s;
    if (rst) return '0;
    if (hold) return s;
    n.pc = id_pc; n.rs1d = id_rs1_data; n.rs2d = id_rs2_data; n.imm = id_imm;
    n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
    if (ex_flush) begin
      n.valid = 1'b0; n.ctrl = '0; n.pend = 0; n.flushes = s.flushes + 1;
    end else if (s.pend != 0 || m_hazard(s)) begin
      n.valid = 1'b0; n.ctrl = '0; n.stalls = s.stalls + 1;
      n.pend = (s.pend != 0) ? s.pend - 1 : 8'(bubbles - 1);
    end else begin
      n.valid = id_valid;
      n.ctrl = id_ctrl;
      if (!id_valid) begin
        n.ctrl.reg_write = 1'b0; n.ctrl.mem_read = 1'b0;
        n.ctrl.mem_write = 1'b0; n.ctrl.branch = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= m_next(m[0], 1);
    m[1] <= m_next(m[1], 2);
  end

  task automatic cmp_inst(input int g);
    ctrl_t act_ctrl;
    act_ctrl = '{ex_reg_write[g], ex_mem_read[g], ex_mem_write[g], ex_mem_to_reg[g],
                 ex_alu_src[g], ex_branch[g], ex_alu_op[g]};
    check("pc_write", g, 64'(pc_write[g]), 64'(m_frontend_go(m[g])));
    check("if_id_write", g, 64'(if_id_write[g]), 64'(m_frontend_go(m[g])));
    check("ex_valid", g, 64'(ex_valid[g]), 64'(m[g].valid));
    check("ex_ctrl", g, 64'(act_ctrl), 64'(m[g].ctrl));
    if (m[g].valid) begin
      check("ex_pc", g, 64'(ex_pc[g]), 64'(m[g].pc));
      check("ex_rs1_data", g, 64'(ex_rs1_data[g]), 64'(m[g].rs1d));
      check("ex_rs2_data", g, 64'(ex_rs2_data[g]), 64'(m[g].rs2d));
      check("ex_imm", g, 64'(ex_imm[g]), 64'(m[g].imm));
      check("ex_regs", g, 64'({ex_rs1[g], ex_rs2[g], ex_rd[g]}),
            64'({m[g].rs1, m[g].rs2, m[g].rd}));
    end
`ifdef ID_EX_PERF_CNT_EN
    check("stall_cycles", g, 64'(stall_cycles[g]), 64'(m[g].stalls));
    check("flush_cycles", g, 64'(flush_cycles[g]), 64'(m[g].flushes));
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0);
      cmp_inst(1);
    end
  end

  function automatic ctrl_t mk(bit rw, bit mr, bit m2r, bit as, logic [3:0] op);
    ctrl_t c = '0;
    c.reg_write = rw; c.mem_read = mr; c.mem_to_reg = m2r; c.alu_src = as; c.alu_op = op;
    return c;
  endfunction

  task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input bit u1,
                        input bit u2, input ctrl_t c);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = c;
    id_rs1_data = pc ^ 32'hA5A5_0000;
    id_rs2_data = pc + 32'd17;
    id_imm = {pc[15:0], 16'h00F0};
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  ctrl_t alu_c, lw_c;

  initial begin
    alu_c = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    lw_c  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    rst = 1'b1; hold = 1'b0; ex_flush = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
    tick; tick;
    rst = 1'b0;
    chk_en = 1'b1;
    for (int g = 0; g < 2; g++) begin
      check("rst_ex_valid", g, 64'(ex_valid[g]), 64'd0);
      check("rst_ex_pc", g, 64'(ex_pc[g]), 64'd0);
      check("rst_pc_write", g, 64'(pc_write[g]), 64'd1);
    end

    // Normal flow
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, alu_c);
    settle; check("norm_pc_write", 0, 64'(pc_write[0]), 64'd1);
    tick;
    check("norm_ex_rd", 0, 64'(ex_rd[0]), 64'd5);
    check("norm_ex_rw", 0, 64'(ex_reg_write[0]), 64'd1);
    check("norm_ex_valid", 0, 64'(ex_valid[0]), 64'd1);

    // Load-use: lw x5 then add x7, x6, x5
    set_id(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, lw_c); tick;
    set_id(1'b1, 32'h108, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, alu_c);
    settle;
    for (int g = 0; g < 2; g++) begin
      check("lu_pc_write", g, 64'(pc_write[g]), 64'd0);
      check("lu_if_id_write", g, 64'(if_id_write[g]), 64'd0);
    end
    tick;
    check("lu_bubble_valid", 0, 64'(ex_valid[0]), 64'd0);
    check("lu_bubble_ctrl", 0, 64'({ex_reg_write[0], ex_mem_read[0], ex_alu_op[0]}), 64'd0);
    settle;
    check("lu1_release", 0, 64'(pc_write[0]), 64'd1);
    check("lu2_second_stall", 1, 64'(pc_write[1]), 64'd0);
    tick;
    check("lu1_add_loads", 0, 64'(ex_rd[0]), 64'd7);
    check("lu2_bubble2", 1, 64'(ex_valid[1]), 64'd0);
    settle; check("lu2_release", 1, 64'(pc_write[1]), 64'd1);
    tick;
    check("lu2_add_loads", 1, 64'({ex_valid[1], ex_rd[1]}), 64'({1'b1, 5'd7}));

    // No false hazards: lw x0, unused source, invalid load
    set_id(1'b1, 32'h10C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, lw_c); tick;
    set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, alu_c);
    settle; check("nf_rd_x0", 0, 64'(pc_write[0]), 64'd1); tick;
    set_id(1'b1, 32'h114, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, lw_c); tick;
    set_id(1'b1, 32'h118, 5'd9, 5'd3, 5'd10, 1'b0, 1'b1, alu_c);
    settle; check("nf_unused_rs1", 1, 64'(pc_write[1]), 64'd1); tick;
    set_id(1'b0, 32'h11C, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, lw_c); tick;
    set_id(1'b1, 32'h120, 5'd9, 5'd9, 5'd11, 1'b1, 1'b1, alu_c);
    settle; check("nf_ex_invalid", 0, 64'(pc_write[0]), 64'd1);
    check("nf_invalid_mem_read", 0, 64'(ex_mem_read[0]), 64'd0); tick;

    // Flush beats stall
    set_id(1'b1, 32'h124, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, lw_c); tick;
    set_id(1'b1, 32'h128, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, alu_c);
    ex_flush = 1'b1;
    settle;
    for (int g = 0; g < 2; g++) check("fs_pc_write", g, 64'(pc_write[g]), 64'd1);
    tick;
    ex_flush = 1'b0;
    settle;
    for (int g = 0; g < 2; g++) begin
      check("fs_bubble", g, 64'(ex_valid[g]), 64'd0);
      check("fs_no_pending", g, 64'(pc_write[g]), 64'd1);
    end
    tick;
    for (int g = 0; g < 2; g++) check("fs_add_loads", g, 64'(ex_rd[g]), 64'd7);

    // Hold with flush pending, then flush after hold drops
    set_id(1'b1, 32'h200, 5'd12, 5'd13, 5'd11, 1'b1, 1'b1, alu_c); tick;
`ifdef ID_EX_PERF_CNT_EN
    for (int g = 0; g < 2; g++) flush_base[g] = flush_cycles[g];
`endif
    hold = 1'b1; ex_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h300 + 32'(4 * i), 5'd1, 5'd2, 5'(20 + i), 1'b1, 1'b1, alu_c);
      settle; check("hold_pc_write", 0, 64'(pc_write[0]), 64'd0);
      tick;
      check("hold_ex_kept", i % 2, 64'({ex_valid[i % 2], ex_rd[i % 2], ex_pc[i % 2]}),
            64'({1'b1, 5'd11, 32'h200}));
    end
    hold = 1'b0;
    settle; check("unhold_pc_write", 1, 64'(pc_write[1]), 64'd1);
    tick;
    ex_flush = 1'b0;
    for (int g = 0; g < 2; g++) check("unhold_flush_bubble", g, 64'(ex_valid[g]), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
    for (int g = 0; g < 2; g++) begin
      check("perf_flush_delta", g, 64'(flush_cycles[g] - flush_base[g]), 64'd1);
      check("perf_flush_total", g, 64'(flush_cycles[g]), 64'd2);
    end
    check("perf_stall_u1", 0, 64'(stall_cycles[0]), 64'd1);
    check("perf_stall_u2", 1, 64'(stall_cycles[1]), 64'd2);
`endif

    // Reset mid-stall on the two-bubble instance
    set_id(1'b1, 32'h400, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, lw_c); tick;
    set_id(1'b1, 32'h404, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, alu_c); tick;
    settle; check("ms_stalled", 1, 64'(pc_write[1]), 64'd0);
    rst = 1'b1;
    settle; check("ms_rst_pc_write", 1, 64'(pc_write[1]), 64'd1);
    tick;
    rst = 1'b0;
    settle;
    check("ms_cleared", 1, 64'({ex_valid[1], pc_write[1]}), 64'({1'b0, 1'b1}));
    tick;
    check("ms_proceeds", 1, 64'({ex_valid[1], ex_rd[1]}), 64'({1'b1, 5'd7}));
    tick; tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush for the 5-stage RV32I pipeline.
- Sits between decode and execute.
- Its registered ex_rs1/ex_rs2/ex_rd/ex_reg_write outputs feed the EX-stage forwarding unit and ALU operand muxes.
- Its pc_write/if_id_write outputs freeze the IF and IF/ID stages.

Parameters:
- XLEN, 32, datapath width.
- LOAD_USE_BUBBLES, 1, number of bubbles inserted per load-use hazard (legal range 1..3).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  decode PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads that source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1  decoded controls
- id_alu_op  in  4  ALU operation
- ex_flush  in  1  branch/jump taken in EX; kill the decode instruction
- hold  in  1  global freeze from a memory stall
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op  out  matching widths  registered ID/EX contents
- pc_write  out  1  PC may advance
- if_id_write  out  1  IF/ID may load

Behaviour:
- Reset:
  - All ex_* outputs are 0. ex_valid=0.
  - Bubble counter bcnt=0.
  - pc_write=1, if_id_write=1 combinationally, unless hold is asserted.
- Hazard detect (combinational), true when all of the following hold:
  - ex_valid, ex_mem_read and ex_rd!=0;
  - and either (id_uses_rs1 and ex_rd==id_rs1) or (id_uses_rs2 and ex_rd==id_rs2);
  - and id_valid.
- Per-cycle priority: rst > hold > ex_flush > (hazard or bcnt!=0) > normal load.
- hold:
  - All ex_* registers and bcnt keep their values.
  - pc_write=0, if_id_write=0.
  - A concurrent ex_flush is ignored this cycle. The flush source is frozen too, so it re-presents.
- ex_flush:
  - Load a bubble: ex_valid=0, all control bits and ex_alu_op=0. Data and index fields may load but are don't-care.
  - bcnt=0.
  - pc_write=1, if_id_write=1 (IF/ID flush is handled externally).
- Stall, when hazard with bcnt==0:
  - Load a bubble.
  - bcnt = LOAD_USE_BUBBLES-1.
  - pc_write=0, if_id_write=0.
- Stall, when bcnt!=0:
  - Load a bubble.
  - bcnt decrements.
  - pc_write=0, if_id_write=0.
  - The hazard is not re-evaluated; the bubble count is fixed at detection.
- Normal: all ex_* load from id_*. ex_valid=id_valid.
- Bubble invariant: whenever ex_valid=0, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch are 0. Forwarding therefore never matches a bubble.
- Latency: one cycle, id_* to ex_*.
- Stall cost: exactly LOAD_USE_BUBBLES cycles with pc_write low per hazard.
- Reset asserted mid-stall clears bcnt. The next cycle proceeds normally.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, the block adds two free-running 32-bit counters, reset to 0:
  - stall_cycles, incremented on every cycle in which a stall bubble is loaded;
  - flush_cycles, incremented on every ex_flush cycle not overridden by hold.
- Both counters wrap from 0xFFFFFFFF to 0. Neither increments during hold.
- Both counters are exposed as extra outputs stall_cycles[31:0] and flush_cycles[31:0].
- When undefined, those ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - ctrl_t, a packed struct of reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op;
  - constant CTRL_NOP (all zero);
  - REG_X0=5'd0.
- One sub-module: load_use_detect. It is the combinational hazard compare and is reused by a future stall-on-branch path.
- The bubble counter and registers stay in the top module.

Test Plan:
- Normal flow: id_rd=5, id_reg_write=1, id_valid=1, no hazard.
  - Required: next cycle ex_rd=5, ex_reg_write=1, ex_valid=1; pc_write stays 1.
- Load-use, LOAD_USE_BUBBLES=1: lw x5 in EX (ex_mem_read=1, ex_rd=5); decode add with id_rs2=5, id_uses_rs2=1.
  - Required: pc_write=0 and if_id_write=0 for one cycle; next ex_valid=0 with all controls 0; following cycle the add loads.
- No false hazard cases; each must produce no stall:
  - ex_rd=0 with ex_mem_read=1;
  - rs matches but id_uses_rs1=0;
  - ex_valid=0.
- LOAD_USE_BUBBLES=2: same hazard as above.
  - Required: exactly 2 consecutive bubbles, pc_write low 2 cycles, bcnt returns to 0.
- Flush vs stall: hazard and ex_flush asserted in the same cycle.
  - Required: bubble loaded, pc_write=1, bcnt=0.
- Hold then flush: hold=1 for 3 cycles while id_* changes and ex_flush=1.
  - Required: ex_* unchanged; pc_write=0.
  - After hold drops with ex_flush still 1: bubble loaded.
  - With ID_EX_PERF_CNT_EN defined: flush_cycles=1.
